// File: rtl/tff_bank.sv
// ----------------------------------------------------------------------------
// tff_bank
//   Parametrised bank of WIDTH T flip-flops sharing one clock and one
//   asynchronous active-high reset. Four operating modes are selected by
//   'mode': level-toggle, rising-edge-toggle, synchronous binary counter and
//   hold. A synchronous parallel load overrides every mode.
//
//   Optional feature: define TFF_BANK_DOWN_EN to add the 'dir' port, which
//   makes the counter mode count down when dir=1 (carry_out then flags the
//   borrow from all-zeros to all-ones). Without the macro the counter only
//   counts up and 'dir' does not exist.
//
// Parameters
//   WIDTH     number of flip-flops / counter bits (>= 2)
//   RST_VAL   value loaded into q on reset
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active-high
//   t          in   WIDTH  per-bit toggle inputs; t[0] is count enable in counter mode
//   mode       in   2      00 level-toggle, 01 edge-toggle, 10 counter, 11 hold
//   load       in   1      synchronous parallel load (highest priority after rst)
//   load_val   in   WIDTH  value loaded when load=1
//   dir        in   1      counter direction, 0 up / 1 down (TFF_BANK_DOWN_EN only)
//   q          out  WIDTH  flip-flop outputs
//   carry_out  out  1      registered wrap/borrow pulse, counter mode only
// ----------------------------------------------------------------------------
module tff_bank #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] t,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef TFF_BANK_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] q,
    output logic             carry_out
);

    localparam logic [1:0] ModeLevel = 2'b00;
    localparam logic [1:0] ModeEdge  = 2'b01;
    localparam logic [1:0] ModeCount = 2'b10;
    localparam logic [1:0] ModeHold  = 2'b11;

    localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] OneVal  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] t_prev;
    logic [WIDTH-1:0] q_next;
    logic             carry_next;
    logic             count_down;

`ifdef TFF_BANK_DOWN_EN
    assign count_down = dir;
`else
    assign count_down = 1'b0;
`endif

    always_comb begin
        q_next     = q;
        carry_next = 1'b0;
        if (load) begin
            q_next = load_val;
        end else begin
            unique case (mode)
                ModeLevel: q_next = q ^ t;
                // Toggle only on a 0->1 transition seen across two samples.
                ModeEdge:  q_next = q ^ (t & ~t_prev);
                ModeCount: begin
                    if (t[0]) begin
                        if (count_down) begin
                            q_next     = q - OneVal;
                            carry_next = (q == '0);
                        end else begin
                            q_next     = q + OneVal;
                            carry_next = (q == AllOnes);
                        end
                    end
                end
                ModeHold:  q_next = q;
                default:   q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q         <= RST_VAL;
            carry_out <= 1'b0;
            t_prev    <= '0;
        end else begin
            q         <= q_next;
            carry_out <= carry_next;
            // Tracks t in every mode so entering edge mode with t high is not an edge.
            t_prev    <= t;
        end
    end

endmodule

// File: tb/tb_tff_bank.sv
// ----------------------------------------------------------------------------
// tb_tff_bank
//   Self-checking bench for tff_bank with WIDTH=4, RST_VAL=0. A reference
//   model computes q and carry_out from the mode rules with plain arithmetic
//   and is compared against the DUT one time unit after every rising edge.
//   Directed steps additionally pin hand-computed literal values.
// ----------------------------------------------------------------------------
module tb_tff_bank;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] t;
    logic [1:0]   mode;
    logic         load;
    logic [W-1:0] load_val;
    logic         dir;
    logic [W-1:0] q;
    logic         carry_out;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model state
    int m_q     = 0;
    int m_tprev = 0;
    bit m_carry = 1'b0;

    tff_bank #(
        .WIDTH   (W),
        .RST_VAL (4'b0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .t         (t),
        .mode      (mode),
        .load      (load),
        .load_val  (load_val),
`ifdef TFF_BANK_DOWN_EN
        .dir       (dir),
`endif
        .q         (q),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update on the edge from stable inputs, then compare.
    always @(posedge clk) begin
        int ti;
        int tb;
        ti = int'(t);
        if (rst) begin
            m_q     = 0;
            m_tprev = 0;
            m_carry = 1'b0;
        end else begin
            m_carry = 1'b0;
            if (load) begin
                m_q = int'(load_val);
            end else if (mode == 2'd0) begin
                m_q = m_q ^ ti;
            end else if (mode == 2'd1) begin
                for (int i = 0; i < W; i++) begin
                    tb = 1 << i;
                    if ((ti & tb) != 0 && (m_tprev & tb) == 0) m_q = m_q ^ tb;
                end
            end else if (mode == 2'd2 && ti % 2 == 1) begin
`ifdef TFF_BANK_DOWN_EN
                if (dir) begin
                    m_carry = (m_q == 0);
                    m_q     = (m_q + (1 << W) - 1) % (1 << W);
                end else begin
                    m_carry = (m_q == (1 << W) - 1);
                    m_q     = (m_q + 1) % (1 << W);
                end
`else
                m_carry = (m_q == (1 << W) - 1);
                m_q     = (m_q + 1) % (1 << W);
`endif
            end
            m_tprev = ti;
        end
        #1;
        if (chk_en) begin
            check("model_q", int'(q), m_q);
            check("model_carry", int'(carry_out), int'(m_carry));
        end
    end

    // Advance one edge and land mid-cycle, after the model compare.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; t = '0; mode = 2'b11; load = 1'b0; load_val = '0; dir = 1'b0;

        // 1. reset for 3 cycles, then hold mode
        repeat (3) step();
        check("reset_q", int'(q), 0);
        check("reset_carry", int'(carry_out), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        repeat (2) step();
        check("hold_after_reset", int'(q), 0);

        // 2. level toggle
        mode = 2'b00; t = 4'b0101;
        step(); check("level_1", int'(q), 5);
        step(); check("level_2", int'(q), 0);
        t = 4'b0000;
        step(); check("level_hold", int'(q), 0);

        // 3. edge toggle: a held level toggles once
        mode = 2'b01; t = 4'b0001;
        step(); check("edge_first", int'(q), 1);
        repeat (3) step();
        check("edge_held", int'(q), 1);
        // entering edge mode with t already high must not toggle
        mode = 2'b00; t = 4'b0010;
        step(); check("level_pre_edge", int'(q), 3);
        mode = 2'b01;
        step(); check("edge_enter_high", int'(q), 3);

        // 4. counter: load zero (no carry), then 16 counts with upper t ignored
        mode = 2'b10; t = 4'b1011; load = 1'b1; load_val = 4'b0000;
        step(); check("load_zero_q", int'(q), 0);
        check("load_zero_carry", int'(carry_out), 0);
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check("count_q", int'(q), (i + 1) % 16);
            check("count_carry", int'(carry_out), (i == 15) ? 1 : 0);
        end
        t = 4'b1110;
        step(); check("count_disabled", int'(q), 0);
        check("count_disabled_carry", int'(carry_out), 0);

        // 5. load while counting, then wrap
        t = 4'b0001; load = 1'b1; load_val = 4'b1110;
        step(); check("load_mid_count", int'(q), 14);
        load = 1'b0;
        step(); check("count_15", int'(q), 15);
        step(); check("wrap_q", int'(q), 0);
        check("wrap_carry", int'(carry_out), 1);
        step(); check("after_wrap_carry", int'(carry_out), 0);

        // load overrides hold mode
        mode = 2'b11; load = 1'b1; load_val = 4'b1001;
        step(); check("load_in_hold", int'(q), 9);
        load = 1'b0; t = 4'b1111;
        step(); check("hold_ignores_t", int'(q), 9);

        // 6. async reset mid-cycle from 0111
        mode = 2'b10; t = 4'b0000; load = 1'b1; load_val = 4'b0111;
        step(); check("load_7", int'(q), 7);
        load = 1'b0;
        #1 rst = 1'b1;
        #1 check("async_rst_q", int'(q), 0);
        check("async_rst_carry", int'(carry_out), 0);
        step();
        rst = 1'b0;

`ifdef TFF_BANK_DOWN_EN
        mode = 2'b10; t = 4'b0001; dir = 1'b1;
        step(); check("down_borrow_q", int'(q), 15);
        check("down_borrow_carry", int'(carry_out), 1);
        step(); check("down_14", int'(q), 14);
        dir = 1'b0;
`endif

        // Mixed stimulus, checked by the model only
        for (int i = 0; i < 60; i++) begin
            mode     = 2'($urandom_range(0, 3));
            t        = 4'($urandom);
            load     = ($urandom_range(0, 7) == 0);
            load_val = 4'($urandom);
            dir      = 1'($urandom);
            step();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
